// File: rtl/mips_defs.sv
// Shared definitions for the mips run/reset controller and the cores that reuse its pieces.
// State encodings, halt-cause codes and the halt-priority helper.
package mips_defs;

    typedef logic [1:0] state_t;
    typedef logic [1:0] halt_cause_t;

    localparam state_t ST_HOLD = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_STEP = 2'd2;
    localparam state_t ST_HALT = 2'd3;

    localparam halt_cause_t HC_NONE   = 2'd0;
    localparam halt_cause_t HC_SPIN   = 2'd1;
    localparam halt_cause_t HC_BUDGET = 2'd2;
    localparam halt_cause_t HC_EXT    = 2'd3;

    // External stop outranks spin, which outranks the cycle budget.
    function automatic halt_cause_t halt_cause_pick(input logic ext, input logic spin,
                                                    input logic budget);
        halt_cause_t cause;
        cause = HC_NONE;
        if (ext) begin
            cause = HC_EXT;
        end else if (spin) begin
            cause = HC_SPIN;
        end else if (budget) begin
            cause = HC_BUDGET;
        end
        return cause;
    endfunction

endpackage

// File: rtl/spin_detector.sv
// Flags a PC that stays unchanged for SPIN_LIMIT executed cycles after its first occurrence.
// spin_hit is combinational in the executing cycle; state only advances when exec is high.
module spin_detector
    import mips_defs::*;
#(
    parameter int SPIN_LIMIT = 8,
    parameter int PC_W       = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            exec,
    input  logic [PC_W-1:0] pc,
    output logic            spin_hit
);

    localparam int SC_W = (SPIN_LIMIT > 0) ? $clog2(SPIN_LIMIT + 1) : 1;
    localparam bit SPIN_EN = (SPIN_LIMIT != 0);
    localparam logic [SC_W-1:0] SPIN_TGT = (SPIN_LIMIT > 0) ? SC_W'(SPIN_LIMIT - 1) : '0;

    logic [PC_W-1:0] pc_prev_q;
    logic [PC_W-1:0] pc_prev_d;
    logic            pc_prev_vld_q;
    logic            pc_prev_vld_d;
    logic [SC_W-1:0] same_cnt_q;
    logic [SC_W-1:0] same_cnt_d;
    logic            pc_match;

    assign pc_match = pc_prev_vld_q && (pc == pc_prev_q);
    assign spin_hit = SPIN_EN && exec && pc_match && (same_cnt_q == SPIN_TGT);

    always_comb begin
        pc_prev_d     = pc_prev_q;
        pc_prev_vld_d = pc_prev_vld_q;
        same_cnt_d    = same_cnt_q;
        if (exec) begin
            pc_prev_d     = pc;
            pc_prev_vld_d = 1'b1;
            // Saturate so a disabled detector never wraps back into a false run.
            if (pc_match) begin
                if (same_cnt_q != '1) begin
                    same_cnt_d = same_cnt_q + SC_W'(1);
                end
            end else begin
                same_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_prev_q     <= '0;
            pc_prev_vld_q <= 1'b0;
            same_cnt_q    <= '0;
        end else begin
            pc_prev_q     <= pc_prev_d;
            pc_prev_vld_q <= pc_prev_vld_d;
            same_cnt_q    <= same_cnt_d;
        end
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run/reset controller for the single-cycle core: timed reset, clock-enable, step mode, halt detection.
// First executed cycle RST_CYCLES+1 cycles after reset release; step_pulse gates cpu_ce combinationally.
module mips_run_ctrl
    import mips_defs::*;
#(
    parameter int RST_CYCLES = 4,
    parameter int MAX_CYCLES = 100000,
    parameter int SPIN_LIMIT = 8,
    parameter int CNT_W      = 32,
    parameter int PC_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  pc,
    input  logic             step_mode,
    input  logic             step_pulse,
    input  logic             halt_req,
    output logic             cpu_rst,
    output logic             cpu_ce,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             halted,
    output logic [1:0]       halt_cause
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam bit BUDGET_EN = (MAX_CYCLES != 0);
    localparam logic [63:0] BUDGET_LAST = (MAX_CYCLES > 0) ? 64'(MAX_CYCLES - 1) : 64'd0;

    state_t            state_q;
    state_t            state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic [CNT_W-1:0]  cycle_cnt_q;
    logic [CNT_W-1:0]  cycle_cnt_d;
    halt_cause_t       halt_cause_q;
    halt_cause_t       halt_cause_d;

    logic exec;
    logic spin_hit;
    logic budget_hit;
    logic any_halt;

    assign cpu_rst    = (state_q == ST_HOLD);
    assign cpu_ce     = (state_q == ST_HOLD) || (state_q == ST_RUN)
                     || ((state_q == ST_STEP) && step_pulse);
    assign halted     = (state_q == ST_HALT);
    assign cycle_cnt  = cycle_cnt_q;
    assign halt_cause = halt_cause_q;

    // HOLD also drives cpu_ce so the core sees its reset, but that is not an executed cycle.
    assign exec       = cpu_ce && ((state_q == ST_RUN) || (state_q == ST_STEP));
    assign budget_hit = BUDGET_EN && exec && (64'(cycle_cnt_q) == BUDGET_LAST);
    assign any_halt   = halt_req || spin_hit || budget_hit;

    spin_detector #(
        .SPIN_LIMIT (SPIN_LIMIT),
        .PC_W       (PC_W)
    ) u_spin (
        .clk      (clk),
        .reset    (reset),
        .exec     (exec),
        .pc       (pc),
        .spin_hit (spin_hit)
    );

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        halt_cause_d = halt_cause_q;
        case (state_q)
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = step_mode ? ST_STEP : ST_RUN;
                end
            end
            ST_RUN, ST_STEP: begin
                if (exec && (cycle_cnt_q != '1)) begin
                    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                end
                // The halting cycle itself still executes and is counted above.
                if (any_halt) begin
                    state_d      = ST_HALT;
                    halt_cause_d = halt_cause_pick(halt_req, spin_hit, budget_hit);
                end else begin
                    state_d = step_mode ? ST_STEP : ST_RUN;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= '0;
            cycle_cnt_q  <= '0;
            halt_cause_q <= HC_NONE;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            halt_cause_q <= halt_cause_d;
        end
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench for mips_run_ctrl: two parameterisations share stimulus, each with its own model.
// Driver pushes expected per-cycle outputs; a monitor pops and compares just before each rising edge.
module tb_mips_run_ctrl;

    typedef struct packed {
        logic [31:0] rst_left;
        logic        halted;
        logic [1:0]  cause;
        logic [63:0] cnt;
        logic        stepping;
        logic [31:0] run_len;
        logic [31:0] last_pc;
    } model_t;

    typedef struct packed {
        logic        rst;
        logic        ce;
        logic [31:0] cnt;
        logic        halted;
        logic [1:0]  cause;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] pc;
    logic        step_mode;
    logic        step_pulse;
    logic        halt_req;

    logic        a_rst, a_ce, a_halted;
    logic [31:0] a_cnt;
    logic [1:0]  a_cause;
    logic        b_rst, b_ce, b_halted;
    logic [3:0]  b_cnt;
    logic [1:0]  b_cause;

    mips_run_ctrl #(
        .RST_CYCLES(4), .MAX_CYCLES(20), .SPIN_LIMIT(8), .CNT_W(32), .PC_W(32)
    ) dut_a (
        .clk(clk), .reset(reset), .pc(pc), .step_mode(step_mode), .step_pulse(step_pulse),
        .halt_req(halt_req), .cpu_rst(a_rst), .cpu_ce(a_ce), .cycle_cnt(a_cnt),
        .halted(a_halted), .halt_cause(a_cause)
    );

    mips_run_ctrl #(
        .RST_CYCLES(1), .MAX_CYCLES(0), .SPIN_LIMIT(0), .CNT_W(4), .PC_W(32)
    ) dut_b (
        .clk(clk), .reset(reset), .pc(pc), .step_mode(step_mode), .step_pulse(step_pulse),
        .halt_req(halt_req), .cpu_rst(b_rst), .cpu_ce(b_ce), .cycle_cnt(b_cnt),
        .halted(b_halted), .halt_cause(b_cause)
    );

    int     checks = 0;
    int     errors = 0;
    model_t ma;
    model_t mb;
    obs_t   qa[$];
    obs_t   qb[$];

    function automatic model_t model_reset(input int rstc);
        model_t m;
        m = '0;
        m.rst_left = 32'(rstc);
        return m;
    endfunction

    function automatic obs_t expect_of(input model_t m, input logic sp);
        obs_t o;
        o.rst    = (m.rst_left != 0);
        o.halted = m.halted;
        o.cause  = m.cause;
        o.cnt    = m.cnt[31:0];
        o.ce     = o.rst || (!m.halted && (!m.stepping || sp));
        return o;
    endfunction

    // One clock of the controller described as: reset countdown, then executed cycles
    // counted and PC runs measured, halting on the highest-priority condition seen.
    function automatic model_t advance(input model_t m, input logic rst_n, input logic sm,
                                       input logic sp, input logic hr, input logic [31:0] pcv,
                                       input int rstc, input int maxc, input int spinl,
                                       input int cntw);
        model_t n;
        logic ex, spin, bud;
        logic [63:0] cap;
        n = m;
        if (!rst_n) return model_reset(rstc);
        if (n.rst_left != 0) begin
            n.rst_left = n.rst_left - 1;
            if (n.rst_left == 0) n.stepping = sm;
            return n;
        end
        if (n.halted) return n;
        ex   = !n.stepping || sp;
        spin = 1'b0;
        bud  = 1'b0;
        if (ex) begin
            cap = (64'd1 << cntw) - 64'd1;
            bud = (maxc != 0) && (n.cnt == 64'(maxc - 1));
            if (n.cnt < cap) n.cnt = n.cnt + 64'd1;
            if (n.run_len != 0 && pcv == n.last_pc) n.run_len = n.run_len + 1;
            else n.run_len = 1;
            n.last_pc = pcv;
            spin = (spinl != 0) && (n.run_len == 32'(spinl + 1));
        end
        if (hr) begin
            n.halted = 1'b1; n.cause = 2'd3;
        end else if (spin) begin
            n.halted = 1'b1; n.cause = 2'd1;
        end else if (bud) begin
            n.halted = 1'b1; n.cause = 2'd2;
        end else begin
            n.stepping = sm;
        end
        return n;
    endfunction

    task automatic drive(input logic rst_n, input logic sm, input logic sp, input logic hr,
                         input logic [31:0] pcv, output logic exec_a);
        obs_t ea, eb;
        @(negedge clk);
        reset      = rst_n;
        step_mode  = sm;
        step_pulse = sp;
        halt_req   = hr;
        pc         = pcv;
        ea = expect_of(ma, sp);
        eb = expect_of(mb, sp);
        qa.push_back(ea);
        qb.push_back(eb);
        exec_a = ea.ce && !ea.rst;
        ma = advance(ma, rst_n, sm, sp, hr, pcv, 4, 20, 8, 32);
        mb = advance(mb, rst_n, sm, sp, hr, pcv, 1, 0, 0, 4);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(negedge clk);
            #2;
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_cpu_rst", 32'(a_rst), 32'(e.rst));
                chk("a_cpu_ce", 32'(a_ce), 32'(e.ce));
                chk("a_cycle_cnt", a_cnt, e.cnt);
                chk("a_halted", 32'(a_halted), 32'(e.halted));
                chk("a_halt_cause", 32'(a_cause), 32'(e.cause));
            end
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_cpu_rst", 32'(b_rst), 32'(e.rst));
                chk("b_cpu_ce", 32'(b_ce), 32'(e.ce));
                chk("b_cycle_cnt", 32'(b_cnt), e.cnt);
                chk("b_halted", 32'(b_halted), 32'(e.halted));
                chk("b_halt_cause", 32'(b_cause), 32'(e.cause));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin : stimulus
        logic        ex;
        int          n;
        logic        rst_n, smv, spv, hrv, stick, hit;
        logic [31:0] pv;

        reset = 1'b0; step_mode = 1'b0; step_pulse = 1'b0; halt_req = 1'b0; pc = 32'h0;
        ma = model_reset(4);
        mb = model_reset(1);
        @(posedge clk);

        // PC walks up by 4 from 0x3000 and parks at 0x3010: spin halt on A.
        n = 0;
        for (int i = 0; i < 30; i++) begin
            pv = (n < 4) ? 32'h3000 + 32'(4 * n) : 32'h3010;
            drive(1'b1, 1'b0, 1'b0, 1'b0, pv, ex);
            if (ex) n++;
        end

        // Ever-changing PC: budget halt on A at 20, saturation at 4'hF on B.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h4000, ex);
        for (int i = 0; i < 35; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h4000 + 32'(4 * i), ex);
        end

        // Single-step: three isolated pulses five cycles apart.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h5000, ex);
        n = 0;
        for (int i = 0; i < 22; i++) begin
            spv = (i == 6) || (i == 11) || (i == 16);
            drive(1'b1, 1'b1, spv, 1'b0, 32'h5000 + 32'(4 * n), ex);
            if (ex) n++;
        end

        // External request coinciding with the spin hit, then a one-cycle reset.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h3010, ex);
        for (int i = 0; i < 20; i++) begin
            hit = (ma.rst_left == 0) && !ma.halted && (ma.run_len == 32'd8);
            drive(1'b1, 1'b0, 1'b0, hit, 32'h3010, ex);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h3010, ex);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h3000 + 32'(4 * i), ex);
        end

        // Random mix of resets, mode changes, pulses, stop requests and parked PCs.
        smv = 1'b0; stick = 1'b0; pv = 32'h3000;
        for (int i = 0; i < 2500; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 29) == 0) smv = !smv;
            spv = ($urandom_range(0, 2) == 0);
            hrv = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) stick = !stick;
            if (!stick) pv = 32'h3000 + 32'(4 * $urandom_range(0, 2));
            drive(rst_n, smv, spv, hrv, pv, ex);
        end

        repeat (2) @(negedge clk);
        #4;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Parametrised run/reset controller between the bench (or board) clock/reset and the single-cycle `mips` core.
- Stretches the external reset into a timed CPU reset pulse and gates execution with a clock-enable.
- Counts executed cycles and supports single-step mode.
- Detects termination (PC spin loop, cycle budget, external request), so benches stop on a decided condition instead of free-running.

Parameters:
- RST_CYCLES, 4: cycles `cpu_rst` is held after external reset release; legal range >=1.
- MAX_CYCLES, 100000: cycle budget before forced halt; 0 disables the budget.
- SPIN_LIMIT, 8: consecutive executed cycles with unchanged PC that count as halt; 0 disables spin detection.
- CNT_W, 32: width of `cycle_cnt`.
- PC_W, 32: width of the PC input.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- pc  in  PC_W  current PC from the core.
- step_mode  in  1  1 = single-step execution.
- step_pulse  in  1  in STEP, executes exactly one instruction in the cycle it is high.
- halt_req  in  1  external stop request.
- cpu_rst  out  1  active-high synchronous reset to the core.
- cpu_ce  out  1  core clock-enable (gates PC/GRF/DM writes).
- cycle_cnt  out  CNT_W  executed-cycle count.
- halted  out  1  sticky halt flag.
- halt_cause  out  2  0 none, 1 spin, 2 budget, 3 external.

Behaviour:
- Reset (reset==0 at a posedge):
  - state<=HOLD, hold_cnt<=0, cycle_cnt<=0, halted<=0, halt_cause<=0, pc_prev_vld<=0, same_cnt<=0.
  - Outputs during reset: cpu_rst=1, cpu_ce=1, so the core samples its own reset.
  - Reset asserted in any state, including mid-step or mid-halt, behaves identically.
- States: HOLD, RUN, STEP, HALT. All registers update on posedge clk. Outputs per state:
  - cpu_rst = (state==HOLD).
  - cpu_ce = (state==HOLD) | (state==RUN) | (state==STEP & step_pulse). This is the only combinational path.
  - halted = (state==HALT).
- HOLD:
  - hold_cnt increments each cycle.
  - When hold_cnt==RST_CYCLES-1: next state is STEP if step_mode, else RUN.
  - Exactly RST_CYCLES cycles of cpu_rst=1 follow reset release.
- Executed cycle: any cycle in RUN or STEP where cpu_ce==1. On each executed cycle:
  - cycle_cnt increments, saturating at all-ones (no wrap).
  - If pc_prev_vld && pc==pc_prev, same_cnt increments; otherwise same_cnt<=0.
  - pc_prev<=pc; pc_prev_vld<=1.
  - Non-executed cycles freeze cycle_cnt, same_cnt and pc_prev.
- Halt conditions, evaluated in RUN/STEP; halt_cause is loaded on the same edge that enters HALT:
  - halt_req==1 -> HALT, cause 3. Checked every cycle, executed or not.
  - Spin: SPIN_LIMIT!=0 and an executed cycle with same_cnt==SPIN_LIMIT-1 and pc==pc_prev -> HALT, cause 1. The halt is taken after SPIN_LIMIT identical consecutive PCs following the first.
  - Budget: MAX_CYCLES!=0 and an executed cycle with cycle_cnt==MAX_CYCLES-1 -> HALT, cause 2. cycle_cnt reads exactly MAX_CYCLES in HALT.
  - Simultaneous conditions: priority external > spin > budget.
- RUN -> STEP: when step_mode==1 and no halt condition. The current cycle still executes.
- STEP -> RUN: when step_mode==0. A step_pulse in that same cycle still executes.
- HALT: sticky until reset. cpu_ce=0, all counters frozen, step_pulse and halt_req ignored.
- Latency: first executed cycle is RST_CYCLES+1 cycles after reset release in RUN mode.

Decomposition:
- Shared package `mips_defs`:
  - State encoding HOLD=2'd0, RUN=2'd1, STEP=2'd2, HALT=2'd3.
  - Halt-cause constants HC_NONE/HC_SPIN/HC_BUDGET/HC_EXT.
- One natural sub-module `spin_detector`: holds pc_prev, pc_prev_vld and same_cnt; emits `spin_hit`. Reused later by the pipelined P5 core.
- `cycle_cnt` saturation and the FSM live in the top module.

Test Plan:
- Reset release, RST_CYCLES=4, step_mode=0 -> cpu_rst=1 for exactly 4 cycles; cpu_ce=1 throughout; cycle_cnt=1 after the 5th post-release edge.
- PC increments by 4 from 0x3000, then sticks at 0x3010; SPIN_LIMIT=8 -> halted=1, halt_cause=1 after 8 repeats; cycle_cnt frozen; cpu_ce=0.
- MAX_CYCLES=20, PC always changing -> halted on the edge after cycle 20; cycle_cnt=20; halt_cause=2.
- step_mode=1, three step_pulse singles spaced 5 cycles apart -> cpu_ce high in exactly 3 cycles; cycle_cnt=3; PC sampling only on those cycles.
- halt_req and spin hit in the same cycle -> halt_cause=3. Then reset low for 1 cycle -> halted=0, cycle_cnt=0, state HOLD.
- CNT_W=4, MAX_CYCLES=0, SPIN_LIMIT=0, 20 executed cycles -> cycle_cnt saturates at 4'hF; never halts.
